mem_port2_arbiter: RTL

Shares the OTTER memory's single data port (port 2: address, write data, write enable, read enable, size, sign) between two requesters. Requester A is the CPU load/store path. Requester B is a secondary master such as the program loader or a DMA engine. The block sits between both masters and the memory's port-2 pins. It grants at most one access per idle cycle and holds the read's address, size and sign through the data cycle, because the memory sizes and sign-extends read data from those inputs. A starvation counter guarantees B forward progress under continuous CPU traffic.

---
 rtl/mem_port2_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_port2_arbiter.sv
// rtl/mem_port2_arbiter.sv - two-master arbiter for the OTTER memory data port with B starvation guard
module mem_port2_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        MEM_CLK,
    input  logic        MEM_RST,
    input  logic        A_REQ,
    input  logic        A_WE,
    input  logic [31:0] A_ADDR,
    input  logic [31:0] A_DIN,
    input  logic [1:0]  A_SIZE,
    input  logic        A_SIGN,
    output logic        A_ACK,
    output logic        A_RVALID,
    output logic [31:0] A_RDATA,
    input  logic        B_REQ,
    input  logic        B_WE,
    input  logic [31:0] B_ADDR,
    input  logic [31:0] B_DIN,
    input  logic [1:0]  B_SIZE,
    input  logic        B_SIGN,
    output logic        B_ACK,
    output logic        B_RVALID,
    output logic [31:0] B_RDATA,
    output logic        M_RDEN2,
    output logic        M_WE2,
    output logic [31:0] M_ADDR2,
    output logic [31:0] M_DIN2,
    output logic [1:0]  M_SIZE,
    output logic        M_SIGN,
    input  logic [31:0] M_DOUT2
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD_A = 2'd1;
    localparam logic [1:0] ST_RD_B = 2'd2;
    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

    logic [1:0]  state;
    logic [3:0]  starve_cnt;
    logic [31:0] hold_addr;
    logic [1:0]  hold_size;
    logic        hold_sign;

    logic idle;
    logic b_forced;
    logic grant_a;
    logic grant_b;
    logic rd_a;
    logic rd_b;

    // Reset masks every output, including a read already in its data cycle.
    assign idle     = (state == ST_IDLE) && !MEM_RST;
    assign rd_a     = (state == ST_RD_A) && !MEM_RST;
    assign rd_b     = (state == ST_RD_B) && !MEM_RST;
    assign b_forced = (starve_cnt == LIMIT);
    assign grant_a  = idle && A_REQ && !(B_REQ && b_forced);
    assign grant_b  = idle && B_REQ && (!A_REQ || b_forced);

    always_comb begin
        A_ACK    = 1'b0;
        B_ACK    = 1'b0;
        M_RDEN2  = 1'b0;
        M_WE2    = 1'b0;
        M_ADDR2  = 32'd0;
        M_DIN2   = 32'd0;
        M_SIZE   = 2'd0;
        M_SIGN   = 1'b0;
        A_RVALID = rd_a;
        B_RVALID = rd_b;
        A_RDATA  = rd_a ? M_DOUT2 : 32'd0;
        B_RDATA  = rd_b ? M_DOUT2 : 32'd0;
        if (grant_a) begin
            A_ACK   = 1'b1;
            M_WE2   = A_WE;
            M_RDEN2 = !A_WE;
            M_ADDR2 = A_ADDR;
            M_DIN2  = A_DIN;
            M_SIZE  = A_SIZE;
            M_SIGN  = A_SIGN;
        end else if (grant_b) begin
            B_ACK   = 1'b1;
            M_WE2   = B_WE;
            M_RDEN2 = !B_WE;
            M_ADDR2 = B_ADDR;
            M_DIN2  = B_DIN;
            M_SIZE  = B_SIZE;
            M_SIGN  = B_SIGN;
        end else if (rd_a || rd_b) begin
            // Memory sizes/sign-extends during the data cycle, so keep its inputs steady.
            M_ADDR2 = hold_addr;
            M_SIZE  = hold_size;
            M_SIGN  = hold_sign;
        end
    end

    always_ff @(posedge MEM_CLK) begin
        if (MEM_RST) begin
            state      <= ST_IDLE;
            starve_cnt <= 4'd0;
            hold_addr  <= 32'd0;
            hold_size  <= 2'd0;
            hold_sign  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_a && !A_WE) begin
                        state     <= ST_RD_A;
                        hold_addr <= A_ADDR;
                        hold_size <= A_SIZE;
                        hold_sign <= A_SIGN;
                    end else if (grant_b && !B_WE) begin
                        state     <= ST_RD_B;
                        hold_addr <= B_ADDR;
                        hold_size <= B_SIZE;
                        hold_sign <= B_SIGN;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (!B_REQ || grant_b) begin
                starve_cnt <= 4'd0;
            end else if (grant_a && !b_forced) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule
